// File: rtl/spwm_sine_ref_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spwm_sine_ref_pkg
// Purpose  : Shared definitions for the SPWM sine reference generator:
//            default geometry, MAX/MID helpers, quadrant encodings and the
//            default quarter-wave sine table.
// Revision : 1.0 - initial release
// ============================================================================
package spwm_sine_ref_pkg;

  // Default geometry (counter width, phase width, quarter-table address width)
  localparam int c_n_bits_dflt     = 4;
  localparam int c_phase_bits_dflt = 8;
  localparam int c_lut_addr_dflt   = 3;

  // Quadrant encoding taken from the top two phase bits
  typedef enum logic [1:0] {
    quad0 = 2'd0,  // rising, positive half
    quad1 = 2'd1,  // falling, positive half (mirrored index)
    quad2 = 2'd2,  // falling, negative half
    quad3 = 2'd3   // rising, negative half (mirrored index)
  } quad_t;

  // MAX = 2^n - 1
  function automatic int max_val(input int n);
    return (1 << n) - 1;
  endfunction

  // MID = 2^(n-1)
  function automatic int mid_val(input int n);
    return 1 << (n - 1);
  endfunction

  // round(7 * sin(pi/2 * (k + 0.5) / 8)) for k = 0..7
  function automatic logic [2:0] lut_default(input logic [2:0] k);
    logic [2:0] v;
    v = 3'd7;
    case (k)
      3'd0:    v = 3'd1;
      3'd1:    v = 3'd2;
      3'd2:    v = 3'd3;
      3'd3:    v = 3'd4;
      3'd4:    v = 3'd5;
      3'd5:    v = 3'd6;
      3'd6:    v = 3'd7;
      default: v = 3'd7;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spwm_sine_ref_lut.sv
`default_nettype none
// ============================================================================
// Module   : spwm_sine_ref_lut
// Purpose  : Synchronous-read quarter-wave sine ROM.
// Ports    : clk  - system clock
//            rst  - asynchronous active-low reset
//            addr - table index (LUT_ADDR bits)
//            data - registered amplitude (N_bits-1 bits), valid one cycle
//                   after addr
// Revision : 1.0 - initial release
// ============================================================================
module spwm_sine_ref_lut
  import spwm_sine_ref_pkg::*;
#(
  parameter int N_bits   = c_n_bits_dflt,
  parameter int LUT_ADDR = c_lut_addr_dflt
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LUT_ADDR-1:0] addr,
  output logic [N_bits-2:0]   data
);

  logic [2:0]        w_k;
  logic [N_bits-2:0] r_data;

  // The hard-coded table has 8 entries; other address widths map onto it
  // through the most significant index bits.
  generate
    if (LUT_ADDR >= 3) begin : g_addr_wide
      assign w_k = addr[LUT_ADDR-1 -: 3];
    end else begin : g_addr_narrow
      assign w_k = {addr, {(3-LUT_ADDR){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else begin
      r_data <= (N_bits-1)'(lut_default(w_k));
    end
  end

  assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/spwm_sine_ref.sv
`default_nettype none
// ============================================================================
// Module   : spwm_sine_ref
// Purpose  : Sine reference for the SPWM datapath. Advances a phase
//            accumulator once per PWM period, folds the phase onto a
//            quarter-wave table and hands the comparator a duty word that
//            only changes at the counter wrap.
// Ports    : clk        - system clock
//            rst        - asynchronous active-low reset
//            en         - run enable
//            count_in   - PWM counter value
//            freq_word  - phase increment per PWM period
//            freq_load  - strobe capturing freq_word
//            duty       - duty word for the comparator
//            duty_valid - one-cycle pulse on each duty update
//            sync       - one-cycle pulse when the phase accumulator wraps
// Revision : 1.0 - initial release
// ============================================================================
module spwm_sine_ref
  import spwm_sine_ref_pkg::*;
#(
  parameter int N_bits     = c_n_bits_dflt,
  parameter int PHASE_BITS = c_phase_bits_dflt,
  parameter int LUT_ADDR   = c_lut_addr_dflt
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_bits-1:0]     count_in,
  input  logic [PHASE_BITS-1:0] freq_word,
  input  logic                  freq_load,
  output logic [N_bits-1:0]     duty,
  output logic                  duty_valid,
  output logic                  sync
);

  localparam logic [N_bits-1:0] c_max = N_bits'(max_val(N_bits));
  localparam logic [N_bits-1:0] c_mid = N_bits'(mid_val(N_bits));

  logic [PHASE_BITS-1:0] r_phase;
  logic [PHASE_BITS-1:0] r_freq;
  logic [N_bits-1:0]     r_pend;
  logic [N_bits-1:0]     r_duty;
  logic                  r_dv;
  logic                  r_sync;
  logic                  r_ld;    // LUT output holds a fresh sample
  logic                  r_neg;   // sign of the sample in flight

  logic                  w_bnd;
  logic [PHASE_BITS-1:0] w_freq_eff;
  logic [PHASE_BITS:0]   w_sum;
  quad_t                 w_q;
  logic [LUT_ADDR-1:0]   w_i;
  logic [LUT_ADDR-1:0]   w_idx;
  logic                  w_mirror;
  logic                  w_neg;
  logic [N_bits-2:0]     w_lut;
  logic [N_bits-1:0]     w_amp;
  logic [N_bits-1:0]     w_sample;

  assign w_bnd = en && (count_in == c_max);

  // A load landing on the boundary cycle is used at that boundary.
  assign w_freq_eff = freq_load ? freq_word : r_freq;
  assign w_sum      = {1'b0, r_phase} + {1'b0, w_freq_eff};

  // Quadrant fold: odd quadrants walk the quarter table backwards.
  assign w_q      = quad_t'(r_phase[PHASE_BITS-1 -: 2]);
  assign w_i      = r_phase[PHASE_BITS-3 -: LUT_ADDR];
  assign w_mirror = (w_q == quad1) || (w_q == quad3);
  assign w_neg    = (w_q == quad2) || (w_q == quad3);
  assign w_idx    = w_mirror ? ~w_i : w_i;

  // The ROM reads every cycle; its output one cycle after a boundary
  // belongs to the phase seen at that boundary.
  spwm_sine_ref_lut #(
    .N_bits   (N_bits),
    .LUT_ADDR (LUT_ADDR)
  ) u_lut (
    .clk  (clk),
    .rst  (rst),
    .addr (w_idx),
    .data (w_lut)
  );

  // Amplitude is at most MID-1, so MID +/- A stays within 1..MAX.
  assign w_amp    = {1'b0, w_lut};
  assign w_sample = r_neg ? (c_mid - w_amp) : (c_mid + w_amp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
      r_freq  <= '0;
      r_pend  <= c_mid;
      r_duty  <= c_mid;
      r_dv    <= 1'b0;
      r_sync  <= 1'b0;
      r_ld    <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_dv   <= 1'b0;
      r_sync <= 1'b0;
      r_ld   <= 1'b0;

      if (freq_load) begin
        r_freq <= freq_word;
      end

      if (w_bnd) begin
        r_phase <= w_sum[PHASE_BITS-1:0];
        r_sync  <= w_sum[PHASE_BITS];
        r_duty  <= r_pend;
        r_dv    <= 1'b1;
        r_ld    <= 1'b1;
        r_neg   <= w_neg;
      end

      // Completes a sample taken at a boundary even if en has just dropped,
      // so no sample is lost across an enable gap.
      if (r_ld) begin
        r_pend <= w_sample;
      end
    end
  end

  assign duty       = r_duty;
  assign duty_valid = r_dv;
  assign sync       = r_sync;

endmodule
`default_nettype wire
